// File: rtl/sysid_reader.sv
// sysid_reader: Avalon-MM read master that checks the system-ID and timestamp words against build constants
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0400_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5446_27C2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic id_match_q, id_match_d, ts_match_q, ts_match_d, timeout_q, timeout_d;
  logic avm_read_q, avm_read_d, avm_address_q, avm_address_d, busy_q, busy_d, done_q, done_d;
  logic accept, active, rvalid, last;
  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout     = timeout_q;
  // Next-state, capture and timeout logic; bus strobes are registered from the next state so they never glitch
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    accept = (state_q == RD_ID || state_q == RD_TS) && !avm_waitrequest;
    active = state_q inside {RD_ID, WAIT_ID, RD_TS, WAIT_TS};
    rvalid = (state_q == WAIT_ID || state_q == WAIT_TS) && avm_readdatavalid;
    last   = cnt_q >= CW'(TIMEOUT_CYCLES - 1);
    if (active) cnt_d = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d    = RD_ID;
        cnt_d      = '0;
        id_match_d = 1'b0;
        ts_match_d = 1'b0;
        timeout_d  = 1'b0;
      end
      RD_ID:   if (accept) state_d = WAIT_ID;
      WAIT_ID: if (rvalid) begin
        id_value_d = avm_readdata;
        id_match_d = avm_readdata == EXPECTED_ID;
        state_d    = RD_TS;
        cnt_d      = '0;
      end
      RD_TS:   if (accept) state_d = WAIT_TS;
      WAIT_TS: if (rvalid) begin
        ts_value_d = avm_readdata;
        ts_match_d = avm_readdata == EXPECTED_TS;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (active && last && !rvalid) begin
      state_d    = DONE;
      timeout_d  = 1'b1;
      id_match_d = 1'b0;
      ts_match_d = 1'b0;
    end
    avm_read_d    = state_d == RD_ID || state_d == RD_TS;
    avm_address_d = state_d == RD_TS;
    busy_d        = state_d != IDLE;
    done_d        = state_d == DONE;
  end
  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      id_match_q    <= 1'b0;
      ts_match_q    <= 1'b0;
      timeout_q     <= 1'b0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      id_match_q    <= id_match_d;
      ts_match_q    <= ts_match_d;
      timeout_q     <= timeout_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end
endmodule

// File: tb/tb_sysid_reader.sv
// tb_sysid_reader: table-driven check of the sysid read master against a cycle-level slave model
module tb_sysid_reader;
  localparam logic [31:0] G_ID = 32'h0400_0000;
  localparam logic [31:0] G_TS = 32'h5446_27C2;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic avm_address, avm_read, busy, done, id_match, ts_match, timeout;
  logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0, id_value, ts_value;
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {
    logic [31:0] w0, w1;
    int nwait, lat;
    bit silent;
    int restart, exp_done;
    bit exp_idm, exp_tsm, exp_to;
    logic [31:0] exp_id, exp_ts;
  } seq_t;
  seq_t vec [8];
  sysid_reader #(.EXPECTED_ID(G_ID), .EXPECTED_TS(G_TS), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .id_value(id_value), .ts_value(ts_value),
    .id_match(id_match), .ts_match(ts_match), .timeout(timeout)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic run_seq(input int idx, input seq_t v);
    int stall, pcnt, dcyc;
    bit st_addr, saw1, stab_bad, b1, late_busy;
    stall = 0; pcnt = 0; dcyc = 0; st_addr = 0; saw1 = 0; stab_bad = 0; late_busy = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    b1 = busy;
    for (int c = 1; c < 60; c++) begin
      start = (c == v.restart);
      avm_readdatavalid = 1'b0;
      if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0 && !v.silent) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = st_addr ? v.w1 : v.w0;
        end
      end
      avm_waitrequest = 1'b0;
      if (stall > 0 && !avm_read) stab_bad = 1'b1;
      if (avm_read) begin
        if (avm_address) saw1 = 1'b1;
        if (stall == 0) st_addr = avm_address;
        else if (avm_address !== st_addr) stab_bad = 1'b1;
        if (stall < v.nwait) begin
          avm_waitrequest = 1'b1;
          stall++;
        end else begin
          pcnt = v.lat;
          stall = 0;
        end
      end
      if (done) begin
        dcyc = c;
        break;
      end
      @(negedge clock);
    end
    chk($sformatf("v%0d done_cycle", idx), dcyc, v.exp_done);
    chk($sformatf("v%0d id_match", idx), {31'd0, id_match}, {31'd0, v.exp_idm});
    chk($sformatf("v%0d ts_match", idx), {31'd0, ts_match}, {31'd0, v.exp_tsm});
    chk($sformatf("v%0d timeout", idx), {31'd0, timeout}, {31'd0, v.exp_to});
    chk($sformatf("v%0d id_value", idx), id_value, v.exp_id);
    chk($sformatf("v%0d ts_value", idx), ts_value, v.exp_ts);
    chk($sformatf("v%0d busy_first", idx), {31'd0, b1}, 32'd1);
    chk($sformatf("v%0d ts_read_issued", idx), {31'd0, saw1}, {31'd0, !v.exp_to});
    chk($sformatf("v%0d stall_stable", idx), {31'd0, stab_bad}, 32'd0);
    @(negedge clock);
    start = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    chk($sformatf("v%0d after_done", idx), {29'd0, done, busy, avm_read}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (busy || avm_read) late_busy = 1'b1;
    end
    chk($sformatf("v%0d no_restart", idx), {31'd0, late_busy}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vec[0] = '{G_ID, G_TS, 0, 1, 1'b0, 0, 5, 1'b1, 1'b1, 1'b0, G_ID, G_TS};
    vec[1] = '{32'h0400_0001, G_TS, 0, 1, 1'b0, 2, 5, 1'b0, 1'b1, 1'b0, 32'h0400_0001, G_TS};
    vec[2] = '{G_ID, G_TS, 3, 2, 1'b0, 0, 13, 1'b1, 1'b1, 1'b0, G_ID, G_TS};
    vec[3] = '{G_ID, 32'h1234_5678, 0, 3, 1'b0, 0, 9, 1'b1, 1'b0, 1'b0, G_ID, 32'h1234_5678};
    vec[4] = '{G_ID, G_TS, 6, 1, 1'b0, 0, 17, 1'b1, 1'b1, 1'b0, G_ID, G_TS};
    vec[5] = '{32'h1111_1111, 32'h2222_2222, 7, 1, 1'b0, 0, 9, 1'b0, 1'b0, 1'b1, G_ID, G_TS};
    vec[6] = '{32'h3333_3333, 32'h4444_4444, 0, 1, 1'b1, 0, 9, 1'b0, 1'b0, 1'b1, G_ID, G_TS};
    vec[7] = '{G_ID, G_TS, 0, 2, 1'b0, 5, 7, 1'b1, 1'b1, 1'b0, G_ID, G_TS};
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_ctrl", {25'd0, avm_read, avm_address, busy, done, id_match, ts_match, timeout}, 32'd0);
    chk("reset_id", id_value, 32'd0);
    chk("reset_ts", ts_value, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_seq(i, vec[i]);
    @(negedge clock);
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
    @(negedge clock);
    avm_readdatavalid = 1'b0;
    @(negedge clock);
    chk("stray_id", id_value, G_ID);
    chk("stray_ts", ts_value, G_TS);
    chk("stray_ctrl", {28'd0, busy, done, id_match, ts_match}, 32'd3);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    @(negedge clock) begin avm_readdatavalid = 1'b1; avm_readdata = G_ID; end
    @(negedge clock) avm_readdatavalid = 1'b0;
    @(negedge clock) chk("mid_wait_ts", {30'd0, busy, avm_read}, 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = G_TS;
    chk("midrst_ctrl", {25'd0, avm_read, avm_address, busy, done, id_match, ts_match, timeout}, 32'd0);
    chk("midrst_id", id_value, 32'd0);
    chk("midrst_ts", ts_value, 32'd0);
    @(negedge clock);
    avm_readdatavalid = 1'b0;
    chk("late_resp_ts", ts_value, 32'd0);
    chk("late_resp_ctrl", {28'd0, busy, done, ts_match, timeout}, 32'd0);
    run_seq(8, vec[0]);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
